palette_arbiter: RTL and testbench
==================================

PALETTE_ARBITER -- requirements
Module: palette_arbiter

Interface
REQ-001 SHALL have parameter KEY_INDEX, default 4'h0: the palette index treated as transparent (chroma-key colour).
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port p1_req, input, 1 bit: player-1 sprite pipeline requests a lookup.
REQ-005 SHALL have port p1_index, input, 4 bits: player-1 palette index, held stable while p1_req=1 and p1_gnt=0.
REQ-006 SHALL have port p2_req, input, 1 bit: player-2 request.
REQ-007 SHALL have port p2_index, input, 4 bits: player-2 palette index, same hold rule as p1_index.
REQ-008 SHALL have port p1_gnt, output, 1 bit: player-1 request accepted this cycle.
REQ-009 SHALL have port p2_gnt, output, 1 bit: player-2 request accepted this cycle.
REQ-010 SHALL have port pal_index, output, 4 bits: registered index driven to the shared 16-entry palette ROM.
REQ-011 SHALL have ports pal_red, pal_green and pal_blue, input, 4 bits each: combinational palette outputs for pal_index.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream compositor can accept a pixel.
REQ-013 SHALL have port pix_valid, output, 1 bit: pix_* fields carry a pixel.
REQ-014 SHALL have port pix_owner, output, 1 bit: 0 = player 1, 1 = player 2.
REQ-015 SHALL have port pix_rgb, output, 12 bits: the pixel colour as {red, green, blue}.
REQ-016 SHALL have port pix_transparent, output, 1 bit: the pixel's index equalled KEY_INDEX.

Function
REQ-017 SHALL form a 2-stage pipeline:
- S1: pal_index, s1_valid and s1_owner.
- S2: pix_valid, pix_owner, pix_rgb and pix_transparent.
REQ-018 SHALL compute p1_gnt and p2_gnt combinationally from the requests, the round-robin pointer and the stall signal; at most one grant may be high per cycle.
REQ-019 SHALL define stall = pix_valid & ~out_ready.
REQ-020 SHALL, when stall=1, drive both grants to 0 and hold all S1/S2 registers and the pointer.
REQ-021 SHALL apply the following grant rules when not stalled:
- Only one requester active: that requester is granted.
- Both active: the requester not served last is granted.
- Neither active: no grant.
REQ-022 SHALL, on a grant, set the pointer "last served" to the granted player; the pointer is unchanged in cycles without a grant.
REQ-023 SHALL, on a grant in cycle N:
- Load pal_index with the granted player's index.
- Set s1_valid=1 and s1_owner to the granted player.
- Record the transparency compare of the granted index against KEY_INDEX.
REQ-024 SHALL, when not stalled with no grant, clear s1_valid; pal_index retains its value.
REQ-025 SHALL, when not stalled, load S2 from S1 each cycle:
- pix_rgb = {pal_red, pal_green, pal_blue}.
- pix_valid = s1_valid.
- pix_owner and pix_transparent taken from S1.
REQ-026 SHALL make pix_valid rise in cycle N+2 for a grant in cycle N when there is no stall; latency 2 cycles, throughput 1 pixel/cycle.
REQ-027 SHALL hold pix_* stable while pix_valid=1 and out_ready=0; a pixel is consumed in a cycle where pix_valid=1 and out_ready=1.
REQ-028 SHALL NOT let S1 overwrite S2 during a stall; no pixel is dropped or duplicated.
REQ-029 SHALL use fairness: with both requesters continuously active and no stall, grants alternate P1,P2,P1,...; the worst-case wait is 1 grant slot plus any stall cycles.
REQ-030 SHALL ignore a request that drops before it is granted, with no state change.
REQ-031 SHALL ignore pix_transparent for ordering purposes; transparent pixels are still emitted with pix_rgb from the palette.

Reset
REQ-032 SHALL, when Reset_n=0 at a rising edge, set:
- pal_index=0, s1_valid=0, s1_owner=0.
- pix_valid=0, pix_owner=0, pix_rgb=12'h000, pix_transparent=0.
- The pointer to "P2 last served", so P1 wins the first tie.
REQ-033 SHALL force p1_gnt=0 and p2_gnt=0 while Reset_n=0.
REQ-034 SHALL discard in-flight pixels on reset mid-operation; the first post-reset pixel appears no earlier than 2 cycles after the first post-reset grant.

Verification
REQ-035 SHALL cover single request: the team sprite palette is attached (index 1 = 12'h511, index 0 = 12'hF0F); p1_req=1, p1_index=1 for one cycle with out_ready=1 -> p1_gnt=1 in cycle N, then pix_valid=1, pix_owner=0, pix_rgb=12'h511, pix_transparent=0 in N+2.
REQ-036 SHALL cover the transparent key: p2_req with p2_index=0 -> pix_owner=1, pix_rgb=12'hF0F, pix_transparent=1.
REQ-037 SHALL cover contention: both request continuously for 6 cycles from reset -> grants P1,P2,P1,P2,P1,P2, with pix_owner sequence 0,1,0,1,0,1 two cycles later.
REQ-038 SHALL cover backpressure: out_ready=0 for 3 cycles while pix_valid=1 -> grants 0 and pix_* frozen; after release, pixels resume in order with none lost or duplicated.
REQ-039 SHALL cover reset mid-stream: Reset_n=0 for 1 cycle with both S1 and S2 valid -> pix_valid=0 next cycle, and P1 wins the next tie.
REQ-040 SHALL cover request withdrawal: p2_req pulsed during a P1 grant then dropped -> no P2 grant and the pointer unchanged by the withdrawal.

Source files
------------

// File: rtl/palette_arbiter.sv
// palette_arbiter: round-robin arbitration of two sprite pipelines onto one
// shared palette ROM, followed by a 2-stage lookup pipeline with backpressure.
module palette_arbiter #(
  parameter logic [3:0] KEY_INDEX = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        p1_req,
  input  logic [3:0]  p1_index,
  input  logic        p2_req,
  input  logic [3:0]  p2_index,
  output logic        p1_gnt,
  output logic        p2_gnt,
  output logic [3:0]  pal_index,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  input  logic        out_ready,
  output logic        pix_valid,
  output logic        pix_owner,
  output logic [11:0] pix_rgb,
  output logic        pix_transparent
);

  typedef enum logic {
    LAST_P1 = 1'b0,
    LAST_P2 = 1'b1
  } last_t;

  last_t      last_q;
  logic       s1_valid;
  logic       s1_owner;
  logic       s1_transp;
  logic       stall;
  logic [3:0] gnt_index;

  // Grant decision: stall and reset suppress all grants; ties go to the
  // requester that was not served last.
  always_comb begin
    stall  = pix_valid & ~out_ready;
    p1_gnt = 1'b0;
    p2_gnt = 1'b0;
    if (Reset_n && !stall) begin
      if (p1_req && p2_req) begin
        if (last_q == LAST_P2) p1_gnt = 1'b1;
        else                   p2_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end else if (p2_req) begin
        p2_gnt = 1'b1;
      end
    end
    gnt_index = p2_gnt ? p2_index : p1_index;
  end

  // Pipeline and pointer update; everything holds while stalled.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      last_q          <= LAST_P2;
      pal_index       <= '0;
      s1_valid        <= 1'b0;
      s1_owner        <= 1'b0;
      s1_transp       <= 1'b0;
      pix_valid       <= 1'b0;
      pix_owner       <= 1'b0;
      pix_rgb         <= '0;
      pix_transparent <= 1'b0;
    end else if (!stall) begin
      if (p1_gnt || p2_gnt) begin
        pal_index <= gnt_index;
        s1_valid  <= 1'b1;
        s1_owner  <= p2_gnt;
        s1_transp <= (gnt_index == KEY_INDEX);
        last_q    <= p2_gnt ? LAST_P2 : LAST_P1;
      end else begin
        s1_valid  <= 1'b0;
      end
      pix_valid       <= s1_valid;
      pix_owner       <= s1_owner;
      pix_rgb         <= {pal_red, pal_green, pal_blue};
      pix_transparent <= s1_transp;
    end
  end

endmodule

// File: tb/tb_palette_arbiter.sv
// tb_palette_arbiter: table-driven vectors plus hand-written backpressure and
// reset sequences, with an in-order pixel scoreboard.
module tb_palette_arbiter;

  localparam logic [3:0] KEY = 4'h0;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        p1_req = 1'b0, p2_req = 1'b0;
  logic [3:0]  p1_index = '0, p2_index = '0;
  logic        p1_gnt, p2_gnt;
  logic [3:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic        out_ready = 1'b1;
  logic        pix_valid, pix_owner, pix_transparent;
  logic [11:0] pix_rgb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic       owner;
    logic [11:0] rgb;
    logic       tr;
  } pix_t;
  pix_t sb[$];

  typedef struct {
    logic       rst;
    logic       r1;
    logic [3:0] i1;
    logic       r2;
    logic [3:0] i2;
    logic       rdy;
    logic       g1;
    logic       g2;
    logic       cpv;
    logic       pv;
  } vec_t;
  vec_t tbl[21];

  palette_arbiter #(.KEY_INDEX(KEY)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .p1_req(p1_req), .p1_index(p1_index),
    .p2_req(p2_req), .p2_index(p2_index),
    .p1_gnt(p1_gnt), .p2_gnt(p2_gnt),
    .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .out_ready(out_ready),
    .pix_valid(pix_valid), .pix_owner(pix_owner),
    .pix_rgb(pix_rgb), .pix_transparent(pix_transparent)
  );

  always #5 Clk = ~Clk;

  // Team sprite palette ROM: index 0 = F0F, index 1 = 511, others distinct.
  function automatic logic [11:0] pal(input logic [3:0] i);
    case (i)
      4'h0:    pal = 12'hF0F;
      4'h1:    pal = 12'h511;
      default: pal = {i, ~i, i ^ 4'h5};
    endcase
  endfunction

  always_comb {pal_red, pal_green, pal_blue} = pal(pal_index);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check at negedge+1, update scoreboard.
  task automatic cyc(input string tag, input logic rst, input logic r1, input logic [3:0] i1,
                     input logic r2, input logic [3:0] i2, input logic rdy,
                     input logic eg1, input logic eg2, input logic cpv, input logic epv);
    pix_t e;
    @(negedge Clk);
    Reset_n = ~rst; p1_req = r1; p1_index = i1; p2_req = r2; p2_index = i2; out_ready = rdy;
    #1;
    chk({tag, "_p1_gnt"}, 32'(p1_gnt), 32'(eg1));
    chk({tag, "_p2_gnt"}, 32'(p2_gnt), 32'(eg2));
    if (cpv) chk({tag, "_pix_valid"}, 32'(pix_valid), 32'(epv));
    if (eg1) sb.push_back('{1'b0, pal(i1), i1 == KEY});
    if (eg2) sb.push_back('{1'b1, pal(i2), i2 == KEY});
    if (rst) begin
      sb.delete();
    end else if (pix_valid && rdy) begin
      if (sb.size() == 0) begin
        chk({tag, "_unexpected_pixel"}, 32'(pix_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, "_pix_owner"}, 32'(pix_owner), 32'(e.owner));
        chk({tag, "_pix_rgb"}, 32'(pix_rgb), 32'(e.rgb));
        chk({tag, "_pix_transparent"}, 32'(pix_transparent), 32'(e.tr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           rst r1 i1  r2 i2  rdy g1 g2 cpv pv
    tbl[0]  = '{1, 1, 1,  1, 2,  1,  0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1,  0, 0,  1,  1, 0, 1, 0};
    tbl[2]  = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 0};
    tbl[3]  = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 1};
    tbl[4]  = '{0, 0, 0,  1, 0,  1,  0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 0};
    tbl[6]  = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 1};
    tbl[7]  = '{1, 0, 0,  0, 0,  1,  0, 0, 0, 0};
    tbl[8]  = '{0, 1, 2,  1, 3,  1,  1, 0, 1, 0};
    tbl[9]  = '{0, 1, 4,  1, 3,  1,  0, 1, 1, 0};
    tbl[10] = '{0, 1, 4,  1, 5,  1,  1, 0, 1, 1};
    tbl[11] = '{0, 1, 6,  1, 5,  1,  0, 1, 1, 1};
    tbl[12] = '{0, 1, 6,  1, 7,  1,  1, 0, 1, 1};
    tbl[13] = '{0, 1, 0,  1, 7,  1,  0, 1, 1, 1};
    tbl[14] = '{0, 1, 0,  1, 9,  1,  1, 0, 1, 1};
    tbl[15] = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 1};
    tbl[16] = '{0, 1, 10, 1, 11, 1,  0, 1, 1, 1};
    tbl[17] = '{0, 1, 10, 1, 12, 1,  1, 0, 1, 0};
    tbl[18] = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 1};
    tbl[19] = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 1};
    tbl[20] = '{0, 0, 0,  0, 0,  1,  0, 0, 1, 0};

    for (int i = 0; i < 21; i++)
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].r1, tbl[i].i1, tbl[i].r2, tbl[i].i2,
          tbl[i].rdy, tbl[i].g1, tbl[i].g2, tbl[i].cpv, tbl[i].pv);
    chk("vec_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: three stalled cycles with a pixel waiting, then drain.
    cyc("bp0", 0, 1, 3, 1, 4, 1, 0, 1, 1, 0);
    cyc("bp1", 0, 1, 3, 1, 5, 1, 1, 0, 1, 0);
    for (int s = 0; s < 3; s++) begin
      cyc($sformatf("bp_stall%0d", s), 0, 1, 7, 1, 5, 0, 0, 0, 1, 1);
      chk($sformatf("bp_stall%0d_rgb", s), 32'(pix_rgb), 32'(pal(4'h4)));
      chk($sformatf("bp_stall%0d_owner", s), 32'(pix_owner), 32'd1);
    end
    cyc("bp5", 0, 1, 7, 1, 5, 1, 0, 1, 1, 1);
    cyc("bp6", 0, 1, 7, 0, 0, 1, 1, 0, 1, 1);
    cyc("bp7", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    cyc("bp8", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    cyc("bp9", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream with S1 and S2 both valid; P1 must then win the tie.
    cyc("rs0", 0, 1, 1, 1, 2, 1, 0, 1, 1, 0);
    cyc("rs1", 0, 1, 1, 1, 3, 1, 1, 0, 1, 0);
    cyc("rs2", 1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    cyc("rs3", 0, 1, 5, 1, 6, 1, 1, 0, 1, 0);
    cyc("rs4", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    cyc("rs5", 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    cyc("rs6", 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    chk("rs_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
